// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter: geometry, grant
// states, write-queue entry layout and the pixel-to-address mapping.
package vga_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int AW    = 19;
    localparam int DW    = 24;
    localparam int CW    = 10;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } grant_state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;

    // 640 = 512 + 128, so the row offset needs only two shifts and an add.
    function automatic logic [AW-1:0] pixel_addr(input logic [CW-1:0] h, input logic [CW-1:0] v);
        logic [AW-1:0] hw;
        logic [AW-1:0] vw;
        hw = AW'(h);
        vw = AW'(v);
        if (H_RES == 640) begin
            return (vw << 9) + (vw << 7) + hw;
        end
        return (vw * AW'(H_RES)) + hw;
    endfunction

    function automatic logic in_range(input logic [CW-1:0] h, input logic [CW-1:0] v);
        return (h < CW'(H_RES)) && (v < CW'(V_RES));
    endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Posted-write queue between the pixel writer and the framebuffer port.
// Occupancy is tracked by an explicit counter; full/empty derive from it.
module vga_wr_fifo
    import vga_pkg::*;
#(
    parameter int WQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [AW+DW-1:0]            push_data,
    input  logic                        pop,
    output logic [AW+DW-1:0]            head,
    output logic [$clog2(WQ_DEPTH):0]   count,
    output logic                        full,
    output logic                        empty
);

    localparam int PW   = $clog2(WQ_DEPTH);
    localparam int CNTW = PW + 1;

    logic [AW+DW-1:0] mem [WQ_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNTW'(WQ_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only ever read after
    // being written, and pointers/count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads have fixed 2-cycle latency and
// absolute priority; writer traffic is posted to a queue and drained when idle.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int WQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        disp_req,
    input  logic [CW-1:0]               disp_h,
    input  logic [CW-1:0]               disp_v,
    output logic [DW-1:0]               disp_data,
    output logic                        disp_data_valid,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [CW-1:0]               wr_h,
    input  logic [CW-1:0]               wr_v,
    input  logic [DW-1:0]               wr_data,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_wdata,
    input  logic [DW-1:0]               mem_rdata,
    output logic [$clog2(WQ_DEPTH):0]   wq_count,
    output logic                        wr_err
);

    grant_state_t     state;
    logic             rd_oor;
    logic             rd_zero;
    logic             disp_in_range;
    logic             wr_in_range;
    logic             wr_accept;
    logic             push;
    logic             pop;
    logic             wq_full;
    logic             wq_empty;
    wr_entry_t        push_entry;
    wr_entry_t        head_entry;
    logic [AW+DW-1:0] head_bits;

    assign disp_in_range = in_range(disp_h, disp_v);
    assign wr_in_range   = in_range(wr_h, wr_v);
    assign wr_ready      = !wq_full;
    assign wr_accept     = wr_valid && wr_ready;
    assign push          = wr_accept && wr_in_range;
    assign pop           = !disp_req && !wq_empty;
    assign push_entry    = '{addr: pixel_addr(wr_h, wr_v), data: wr_data};
    assign head_entry    = wr_entry_t'(head_bits);

    vga_wr_fifo #(
        .WQ_DEPTH (WQ_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_bits),
        .count     (wq_count),
        .full      (wq_full),
        .empty     (wq_empty)
    );

    // RAM read data lands one cycle after issue; out-of-range reads return zero
    // in the same slot so scanout latency never changes.
    assign disp_data = (disp_data_valid && !rd_zero) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            mem_en          <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            rd_oor          <= 1'b0;
            rd_zero         <= 1'b0;
            disp_data_valid <= 1'b0;
            wr_err          <= 1'b0;
        end else begin
            disp_data_valid <= (state == RD);
            rd_zero         <= rd_oor;
            if (wr_accept && !wr_in_range) begin
                wr_err <= 1'b1;
            end

            if (disp_req) begin
                state  <= RD;
                mem_en <= disp_in_range;
                mem_we <= 1'b0;
                rd_oor <= !disp_in_range;
                if (disp_in_range) begin
                    mem_addr <= pixel_addr(disp_h, disp_v);
                end
            end else if (pop) begin
                state     <= WR;
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= head_entry.addr;
                mem_wdata <= head_entry.data;
                rd_oor    <= 1'b0;
            end else begin
                state  <= IDLE;
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                rd_oor <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural RAM and read/write
// scoreboards checked by a negedge monitor.
module tb_vga_fb_arbiter;

    typedef struct packed {
        logic [18:0] addr;
        logic [23:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_req = 1'b0;
    logic [9:0]  disp_h = '0;
    logic [9:0]  disp_v = '0;
    logic [23:0] disp_data;
    logic        disp_data_valid;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [9:0]  wr_h = '0;
    logic [9:0]  wr_v = '0;
    logic [23:0] wr_data = '0;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic [2:0]  wq_count;
    logic        wr_err;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;

    logic [23:0] exp_rd [$];
    wr_exp_t     exp_wr [$];
    logic [23:0] ram [0:524287];

    always #5 clk = ~clk;

    vga_fb_arbiter #(.WQ_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .disp_req        (disp_req),
        .disp_h          (disp_h),
        .disp_v          (disp_v),
        .disp_data       (disp_data),
        .disp_data_valid (disp_data_valid),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_h            (wr_h),
        .wr_v            (wr_v),
        .wr_data         (wr_data),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .wq_count        (wq_count),
        .wr_err          (wr_err)
    );

    function automatic logic [23:0] pat(input int a);
        return 24'(a) ^ 24'h5A5A5A;
    endfunction

    initial begin
        for (int a = 0; a < 524288; a++) ram[a] = pat(a);
    end

    // Synchronous single-port RAM: read data valid the cycle after issue.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
            else                 mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every valid scanout and every RAM write is matched in order.
    always @(negedge clk) begin
        if (disp_data_valid === 1'b1) begin
            if (exp_rd.size() == 0) check("rd_unexpected_valid", 64'(disp_data_valid), 64'd0);
            else                    check("rd_data", 64'(disp_data), 64'(exp_rd.pop_front()));
        end
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected_commit", 64'(mem_we), 64'd0);
            end else begin
                wr_exp_t e;
                e = exp_wr.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic rd(input int h, input int v, input logic [23:0] exp);
        disp_req = 1'b1;
        disp_h   = 10'(h);
        disp_v   = 10'(v);
        exp_rd.push_back(exp);
    endtask

    // Offers writes 0..5 at row 100; records each one the DUT accepts.
    task automatic wr_step();
        if (k < 6) begin
            wr_valid = 1'b1;
            wr_h     = 10'(10 + k);
            wr_v     = 10'd100;
            wr_data  = 24'h100000 + 24'(k);
            if (wr_ready) begin
                exp_wr.push_back('{addr: 19'(100 * 640 + 10 + k), data: 24'h100000 + 24'(k)});
                k++;
            end
        end else begin
            wr_valid = 1'b0;
        end
    endtask

    initial begin
        repeat (3) cyc();
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_valid", 64'(disp_data_valid), 64'd0);
        check("rst_wr_err", 64'(wr_err), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_disp_data", 64'(disp_data), 64'd0);
        check("rst_wq_count", 64'(wq_count), 64'd0);
        reset = 1'b0;
        cyc();

        // Scanout only: (5,2) -> 1285.
        rd(5, 2, pat(1285));
        cyc();
        disp_req = 1'b0;
        check("rd_mem_en", 64'(mem_en), 64'd1);
        check("rd_mem_we", 64'(mem_we), 64'd0);
        check("rd_mem_addr", 64'(mem_addr), 64'd1285);
        cyc();
        check("rd_latency_valid", 64'(disp_data_valid), 64'd1);
        cyc();

        // Write in blanking, committed two cycles after acceptance.
        wr_valid = 1'b1;
        wr_h     = 10'd639;
        wr_v     = 10'd479;
        wr_data  = 24'hABCDEF;
        check("wr_ready_empty", 64'(wr_ready), 64'd1);
        exp_wr.push_back('{addr: 19'd307199, data: 24'hABCDEF});
        cyc();
        wr_valid = 1'b0;
        check("wq_count_one", 64'(wq_count), 64'd1);
        check("no_commit_early", 64'(mem_en), 64'd0);
        cyc();
        check("wr_mem_we", 64'(mem_we), 64'd1);
        check("wr_mem_addr", 64'(mem_addr), 64'd307199);
        check("wr_mem_wdata", 64'(mem_wdata), 64'hABCDEF);
        check("wq_count_drained", 64'(wq_count), 64'd0);
        cyc();
        rd(639, 479, 24'hABCDEF);
        cyc();
        disp_req = 1'b0;
        repeat (2) cyc();

        // Priority and backpressure: 20 scanout cycles while offering 6 writes.
        k = 0;
        for (int i = 0; i < 20; i++) begin
            rd(i, 3, pat(3 * 640 + i));
            wr_step();
            check("no_wr_during_rd", 64'(mem_we), 64'd0);
            if (i == 4) begin
                check("wr_ready_full", 64'(wr_ready), 64'd0);
                check("wq_count_full", 64'(wq_count), 64'd4);
            end
            cyc();
        end
        disp_req = 1'b0;
        for (int j = 0; j < 8; j++) begin
            wr_step();
            if (j == 0) begin
                check("full_no_bypass", 64'(wr_ready), 64'd0);
                check("full_count", 64'(wq_count), 64'd4);
                check("last_slot_read", 64'(mem_we), 64'd0);
            end
            if (j >= 1 && j <= 6) check("commit_slot", 64'(mem_we), 64'd1);
            if (j >= 1 && j <= 3) check("wq_count_pushpop", 64'(wq_count), 64'd3);
            if (j == 7) check("wq_count_empty", 64'(wq_count), 64'd0);
            cyc();
        end
        check("all_writes_accepted", 64'(k), 64'd6);

        // Out-of-range write and scanout.
        wr_valid = 1'b1;
        wr_h     = 10'd640;
        wr_v     = 10'd0;
        wr_data  = 24'h123456;
        check("oor_wr_ready", 64'(wr_ready), 64'd1);
        cyc();
        wr_valid = 1'b0;
        check("wr_err_set", 64'(wr_err), 64'd1);
        check("oor_not_queued", 64'(wq_count), 64'd0);
        cyc();
        check("oor_no_access", 64'(mem_en), 64'd0);
        rd(700, 10, 24'h0);
        cyc();
        disp_req = 1'b0;
        check("oor_rd_no_mem_en", 64'(mem_en), 64'd0);
        cyc();
        check("oor_rd_valid", 64'(disp_data_valid), 64'd1);
        check("oor_rd_zero", 64'(disp_data), 64'd0);
        cyc();
        check("wr_err_sticky", 64'(wr_err), 64'd1);

        // Reset with 3 queued writes and one read in flight.
        for (int i = 0; i < 3; i++) begin
            disp_req = 1'b1;
            disp_h   = 10'(50 + i);
            disp_v   = 10'd4;
            if (i < 2) exp_rd.push_back(pat(4 * 640 + 50 + i));
            wr_valid = 1'b1;
            wr_h     = 10'(200 + i);
            wr_v     = 10'd5;
            wr_data  = 24'h200000 + 24'(i);
            cyc();
        end
        disp_req = 1'b0;
        wr_valid = 1'b0;
        check("pre_reset_count", 64'(wq_count), 64'd3);
        reset = 1'b1;
        cyc();
        for (int j = 0; j < 6; j++) begin
            if (j == 2) reset = 1'b0;
            check("post_rst_count", 64'(wq_count), 64'd0);
            check("post_rst_no_we", 64'(mem_we), 64'd0);
            check("post_rst_no_valid", 64'(disp_data_valid), 64'd0);
            if (j == 0) check("post_rst_wr_err", 64'(wr_err), 64'd0);
            cyc();
        end

        check("rd_scoreboard_empty", 64'(exp_rd.size()), 64'd0);
        check("wr_scoreboard_empty", 64'(exp_wr.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
